// File: rtl/avm_sdram_responder.sv
// avm_sdram_responder: Avalon-MM word memory with programmable wait states and fixed-latency pipelined read return
// Ports: clk, rst_n (async, active-low); slave_address/read/write/writedata in; slave_waitrequest,
// slave_readdata, slave_readdatavalid out; proto_err sticky flag for read+write in the same cycle.
module avm_sdram_responder #(
  parameter int    DEPTH_WORDS  = 256,
  parameter int    WAIT_CYCLES  = 2,
  parameter int    READ_LATENCY = 3,
  parameter int    MAX_PENDING  = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  output logic        proto_err
);
  localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(READ_LATENCY + 1);
  typedef logic [31:0] mem_t [DEPTH_WORDS];
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) m[i] = 32'(i);
    return m;
  endfunction
  mem_t mem = init_mem();
  logic [ADDR_BITS-1:0] idx;
  logic [3:0] wcnt, wcnt_nxt;
  logic [READ_LATENCY-1:0] vld;
  logic [31:0] dat [READ_LATENCY];
  logic [PW-1:0] pending;
  logic cmd, retiring, accept, rd_acc, unused_addr;
  assign idx = slave_address[ADDR_BITS+1:2];
  assign unused_addr = ^{slave_address[31:ADDR_BITS+2], slave_address[1:0]};
  assign cmd = slave_read | slave_write;
  assign retiring = vld[READ_LATENCY-1];
  always_comb begin
    pending = '0;
    for (int i = 0; i < READ_LATENCY; i++) pending = pending + PW'(vld[i]);
  end
  // a read retiring this cycle frees its slot, so acceptance at the limit is allowed
  assign accept = cmd && wcnt == 4'(WAIT_CYCLES) && (int'(pending) < MAX_PENDING || retiring);
  assign rd_acc = accept && !slave_write;
  assign wcnt_nxt = (!cmd || accept) ? '0 : (wcnt == 4'(WAIT_CYCLES)) ? wcnt : wcnt + 4'd1;
  assign slave_waitrequest = ~accept;
  assign slave_readdatavalid = vld[READ_LATENCY-1];
  assign slave_readdata = dat[READ_LATENCY-1];
  // data stages only advance with their valid bit so readdata holds between pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
      proto_err <= 1'b0;
    end else begin
      wcnt <= wcnt_nxt;
      vld[0] <= rd_acc;
      if (rd_acc) dat[0] <= mem[idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
      if (slave_read && slave_write) proto_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (accept && slave_write) mem[idx] <= slave_writedata;
endmodule

// File: tb/tb_avm_sdram_responder.sv
// tb_avm_sdram_responder: scoreboard bench for the Avalon-MM SDRAM responder
module tb_avm_sdram_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_read, a_write, a_wait, a_rdv, a_perr;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_read, b_write, b_wait, b_rdv, b_perr;
  logic [31:0] b_addr, b_wdata, b_rdata;
  avm_sdram_responder u0 (
    .clk(clk), .rst_n(rst_n), .slave_address(a_addr), .slave_read(a_read), .slave_write(a_write),
    .slave_writedata(a_wdata), .slave_waitrequest(a_wait), .slave_readdata(a_rdata),
    .slave_readdatavalid(a_rdv), .proto_err(a_perr));
  avm_sdram_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(1)) u1 (
    .clk(clk), .rst_n(rst_n), .slave_address(b_addr), .slave_read(b_read), .slave_write(b_write),
    .slave_writedata(b_wdata), .slave_waitrequest(b_wait), .slave_readdata(b_rdata),
    .slave_readdatavalid(b_rdv), .proto_err(b_perr));
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q [$];
  int acc_q [$];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  always @(negedge clk)
    if (a_rdv) begin
      if (exp_q.size() == 0) chk("unexpected_rdv", {31'b0, a_rdv}, 32'd0);
      else begin
        chk("rdata", a_rdata, exp_q.pop_front());
        chk("latency", cyc - acc_q.pop_front(), 32'd3);
      end
    end
  task automatic cmd(input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] ex);
    int w = 0;
    @(negedge clk);
    a_read = rd; a_write = wr; a_addr = ad; a_wdata = wd;
    #1;
    while (a_wait && w < 100) begin
      @(negedge clk); #1; w++;
    end
    chk("waits", w, 32'd2);
    if (rd && !wr) begin
      exp_q.push_back(ex);
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    a_read = 1'b0; a_write = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk); t++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask
  task automatic chk_reset();
    chk("rst_wait", {31'b0, a_wait}, 32'd1);
    chk("rst_rdv", {31'b0, a_rdv}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_perr", {31'b0, a_perr}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    cmd(1, 0, 32'h10, 0, 32'd4);
    cmd(0, 1, 32'h20, 32'hDEADBEEF, 0);
    cmd(1, 0, 32'h20, 0, 32'hDEADBEEF);
    cmd(1, 0, 32'h00, 0, 32'd0);
    cmd(1, 0, 32'h04, 0, 32'd1);
    cmd(1, 0, 32'h08, 0, 32'd2);
    cmd(1, 0, 32'h404, 0, 32'd1);
    cmd(1, 0, 32'h07, 0, 32'd1);
    drain();
    @(negedge clk);
    chk("rdata_hold", a_rdata, 32'd1);
    chk("perr_clear", {31'b0, a_perr}, 32'd0);
    cmd(1, 1, 32'h30, 32'd7, 0);
    @(negedge clk);
    chk("perr_set", {31'b0, a_perr}, 32'd1);
    cmd(1, 0, 32'h30, 0, 32'd7);
    drain();
    repeat (3) @(negedge clk);
    chk("perr_sticky", {31'b0, a_perr}, 32'd1);
    cmd(1, 0, 32'h10, 0, 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1 chk_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cmd(1, 0, 32'h20, 0, 32'hDEADBEEF);
    drain();
    @(negedge clk);
    b_read = 1'b1; b_addr = 32'h4;
    #1 chk("b_wait0", {31'b0, b_wait}, 32'd0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (b_wait && n < 20);
    chk("b_stall", n, 32'd3);
    chk("b_rdv", {31'b0, b_rdv}, 32'd1);
    chk("b_rdata", b_rdata, 32'd1);
    chk("b_perr", {31'b0, b_perr}, 32'd0);
    b_read = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
